// File: rtl/dma_ctrl_sched.sv
// Multi-channel DMA command scheduler: per-channel descriptor FIFOs feed a
// round-robin arbiter that drives a single len/src/dst/dir/start/done engine.
module dma_ctrl_sched #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    output logic [NUM_CH-1:0]        ch_ready_o,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_src_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_dst_i,
    input  logic [NUM_CH-1:0]        ch_dir_i,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [LEN_W-1:0]         dma_len_o,
    output logic [ADDR_W-1:0]        dma_src_o,
    output logic [ADDR_W-1:0]        dma_dst_o,
    output logic                     dma_dir_o,
    output logic                     dma_start_o,
    input  logic                     dma_done_i,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         done_cnt_o
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int DESC_W = 1 + 2 * ADDR_W + LEN_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_reg, state_next;
    logic [NUM_CH-1:0]   nonempty;
    logic [NUM_CH-1:0]   pop;
    logic [DESC_W-1:0]   head [NUM_CH];
    logic [DESC_W-1:0]   head_sel;
    logic [CH_W-1:0]     grant;
    logic                found;
    logic [CH_W-1:0]     rr_ptr_reg, rr_next;
    logic [CH_W-1:0]     owner_reg;
    logic [NUM_CH-1:0]   ch_done_reg;
    logic [CNT_W-1:0]    done_cnt_reg;
    logic [LEN_W-1:0]    dma_len_reg;
    logic [ADDR_W-1:0]   dma_src_reg, dma_dst_reg;
    logic                dma_dir_reg;

    // Per-channel FIFO; the extra pointer bit separates full from empty.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
        logic [DESC_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
        logic              full, push;

        assign full = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
        assign nonempty[gi]   = (wr_ptr_reg != rd_ptr_reg);
        assign ch_ready_o[gi] = !full;
        assign push           = ch_valid_i[gi] && !full;
        assign head[gi]       = mem[rd_ptr_reg[PTR_W-1:0]];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg[PTR_W-1:0]] <= {ch_dir_i[gi],
                                               ch_dst_i[gi*ADDR_W +: ADDR_W],
                                               ch_src_i[gi*ADDR_W +: ADDR_W],
                                               ch_len_i[gi*LEN_W +: LEN_W]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push)    wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
                if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
            end
        end
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

    always_comb begin
        head_sel = head[grant];
        if (int'(grant) == NUM_CH - 1) rr_next = '0;
        else                           rr_next = grant + CH_W'(1);
        pop = '0;
        if (state_reg == S_IDLE && found) pop[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (found && head_sel[LEN_W-1:0] != '0) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (dma_done_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dma_start_o = (state_reg == S_ISSUE);
        busy_o      = (state_reg != S_IDLE) || (|nonempty);
    end

    // Zero-length descriptors complete straight from IDLE without the engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            ch_done_reg  <= '0;
            done_cnt_reg <= '0;
            dma_len_reg  <= '0;
            dma_src_reg  <= '0;
            dma_dst_reg  <= '0;
            dma_dir_reg  <= 1'b0;
        end else begin
            ch_done_reg <= '0;
            if (state_reg == S_IDLE && found) begin
                rr_ptr_reg <= rr_next;
                owner_reg  <= grant;
                {dma_dir_reg, dma_dst_reg, dma_src_reg, dma_len_reg} <= head_sel;
                if (head_sel[LEN_W-1:0] == '0) begin
                    ch_done_reg  <= NUM_CH'(1) << grant;
                    done_cnt_reg <= done_cnt_reg + CNT_W'(1);
                end
            end
            if (state_reg == S_WAIT && dma_done_i) begin
                ch_done_reg  <= NUM_CH'(1) << owner_reg;
                done_cnt_reg <= done_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign ch_done_o  = ch_done_reg;
    assign done_cnt_o = done_cnt_reg;
    assign dma_len_o  = dma_len_reg;
    assign dma_src_o  = dma_src_reg;
    assign dma_dst_o  = dma_dst_reg;
    assign dma_dir_o  = dma_dir_reg;
endmodule

// File: tb/tb_dma_ctrl_sched.sv
// Directed bench for dma_ctrl_sched (4 channels, depth 4, 4-bit completion counter).
module tb_dma_ctrl_sched;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   ch_valid_i, ch_ready_o, ch_dir_i, ch_done_o;
    logic [127:0] ch_len_i, ch_src_i, ch_dst_i;
    logic [31:0]  dma_len_o, dma_src_o, dma_dst_o;
    logic         dma_dir_o, dma_start_o, dma_done_i, busy_o;
    logic [3:0]   done_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    dma_ctrl_sched #(
        .NUM_CH(4), .FIFO_DEPTH(4), .LEN_W(32), .ADDR_W(32), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
        .ch_len_i(ch_len_i), .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i),
        .ch_dir_i(ch_dir_i), .ch_done_o(ch_done_o),
        .dma_len_o(dma_len_o), .dma_src_o(dma_src_o), .dma_dst_o(dma_dst_o),
        .dma_dir_o(dma_dir_o), .dma_start_o(dma_start_o), .dma_done_i(dma_done_i),
        .busy_o(busy_o), .done_cnt_o(done_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_desc(input int ch, input logic [31:0] len, input logic [31:0] src,
                            input logic [31:0] dst, input logic dir);
        ch_valid_i[ch]          = 1'b1;
        ch_len_i[ch*32 +: 32]   = len;
        ch_src_i[ch*32 +: 32]   = src;
        ch_dst_i[ch*32 +: 32]   = dst;
        ch_dir_i[ch]            = dir;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ch_valid_i = '0;
        dma_done_i = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!dma_start_o && n < 50) begin
            tick();
            n++;
        end
        check_val({tag, "_start_seen"}, 64'(dma_start_o), 64'd1);
    endtask

    // Wait for a start, check the engine fields, answer done 'delay' cycles later.
    task automatic serve(input string tag, input int ch, input logic [31:0] len,
                         input logic [31:0] src, input logic [31:0] dst,
                         input logic dir, input int delay);
        logic [3:0] exp_done;
        wait_start(tag);
        check_val({tag, "_len"}, 64'(dma_len_o), 64'(len));
        check_val({tag, "_src"}, 64'(dma_src_o), 64'(src));
        check_val({tag, "_dst"}, 64'(dma_dst_o), 64'(dst));
        check_val({tag, "_dir"}, 64'(dma_dir_o), 64'(dir));
        tick();
        check_val({tag, "_start_pulse"}, 64'(dma_start_o), 64'd0);
        repeat (delay - 1) tick();
        check_val({tag, "_len_held"}, 64'(dma_len_o), 64'(len));
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
        exp_cnt++;
        exp_done = 4'd1 << ch;
        check_val({tag, "_ch_done"}, 64'(ch_done_o), 64'(exp_done));
        check_val({tag, "_done_cnt"}, 64'(done_cnt_o), 64'(exp_cnt & 15));
        $display("txn %s ch%0d len=%0d src=0x%0h dst=0x%0h dir=%0d cnt=%0d",
                 tag, ch, len, src, dst, dir, done_cnt_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_len_i = '0; ch_src_i = '0; ch_dst_i = '0; ch_dir_i = '0;
        do_reset();

        // Reset state
        check_val("rst_ready", 64'(ch_ready_o), 64'hF);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_start", 64'(dma_start_o), 64'd0);
        check_val("rst_done", 64'(ch_done_o), 64'd0);
        check_val("rst_cnt", 64'(done_cnt_o), 64'd0);
        check_val("rst_len", 64'(dma_len_o), 64'd0);

        // Single descriptor on ch1
        set_desc(1, 32'd64, 32'h1000, 32'h2000, 1'b1);
        tick();
        ch_valid_i = '0;
        check_val("single_no_start_c1", 64'(dma_start_o), 64'd0);
        check_val("single_busy", 64'(busy_o), 64'd1);
        tick();
        check_val("single_start_c2", 64'(dma_start_o), 64'd1);
        serve("single", 1, 32'd64, 32'h1000, 32'h2000, 1'b1, 5);
        check_val("single_idle_busy", 64'(busy_o), 64'd0);
        tick();
        check_val("single_done_pulse", 64'(ch_done_o), 64'd0);

        // Fairness: two descriptors per channel, pushed on consecutive edges
        do_reset();
        for (int c = 0; c < 4; c++)
            set_desc(c, 32'd16 + 32'(c), 32'h100 * 32'(c + 1), 32'h8000 + 32'(c), c[0]);
        tick();
        for (int c = 0; c < 4; c++)
            set_desc(c, 32'd32 + 32'(c), 32'h100 * 32'(c + 1) + 32'd1, 32'h9000 + 32'(c), ~c[0]);
        tick();
        ch_valid_i = '0;
        for (int k = 0; k < 8; k++) begin
            int c;
            c = k % 4;
            if (k < 4)
                serve("rr", c, 32'd16 + 32'(c), 32'h100 * 32'(c + 1), 32'h8000 + 32'(c), c[0], 3);
            else
                serve("rr", c, 32'd32 + 32'(c), 32'h100 * 32'(c + 1) + 32'd1, 32'h9000 + 32'(c), ~c[0], 3);
        end
        tick();
        check_val("rr_busy_end", 64'(busy_o), 64'd0);

        // Full FIFO on ch2 with the engine stalled
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_desc(2, 32'd32, 32'h3000 + 32'(k), 32'h4000 + 32'(k), 1'b0);
            tick();
            check_val("full_ready", 64'(ch_ready_o[2]), (k < 4) ? 64'd1 : 64'd0);
            if (k == 1) begin
                check_val("full_first_start", 64'(dma_start_o), 64'd1);
                check_val("full_first_src", 64'(dma_src_o), 64'h3000);
            end
        end
        set_desc(2, 32'd32, 32'h3005, 32'h4005, 1'b0);
        repeat (3) begin
            tick();
            check_val("full_held", 64'(ch_ready_o[2]), 64'd0);
        end
        check_val("full_busy", 64'(busy_o), 64'd1);
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
        exp_cnt++;
        check_val("full_done0", 64'(ch_done_o), 64'h4);
        check_val("full_still_full", 64'(ch_ready_o[2]), 64'd0);
        tick();
        check_val("full_ready_after_pop", 64'(ch_ready_o[2]), 64'd1);
        check_val("full_second_start", 64'(dma_start_o), 64'd1);
        check_val("full_second_src", 64'(dma_src_o), 64'h3001);
        tick();
        ch_valid_i = '0;
        check_val("full_refilled", 64'(ch_ready_o[2]), 64'd0);
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
        exp_cnt++;
        check_val("full_done1", 64'(ch_done_o), 64'h4);
        for (int k = 2; k < 6; k++)
            serve("full_drain", 2, 32'd32, 32'h3000 + 32'(k), 32'h4000 + 32'(k), 1'b0, 2);
        check_val("full_busy_end", 64'(busy_o), 64'd0);
        check_val("full_cnt", 64'(done_cnt_o), 64'd6);

        // Zero-length descriptor completes without the engine
        set_desc(0, 32'd0, 32'h5000, 32'h6000, 1'b0);
        tick();
        ch_valid_i = '0;
        check_val("zero_no_done_c1", 64'(ch_done_o), 64'd0);
        check_val("zero_no_start_c1", 64'(dma_start_o), 64'd0);
        tick();
        exp_cnt++;
        check_val("zero_done_c2", 64'(ch_done_o), 64'h1);
        check_val("zero_no_start_c2", 64'(dma_start_o), 64'd0);
        check_val("zero_cnt", 64'(done_cnt_o), 64'(exp_cnt & 15));
        tick();
        check_val("zero_pulse_end", 64'(ch_done_o), 64'd0);
        check_val("zero_no_start_c3", 64'(dma_start_o), 64'd0);
        check_val("zero_busy", 64'(busy_o), 64'd0);

        // Reset while waiting on the engine, with one more descriptor queued
        set_desc(3, 32'd8, 32'h7000, 32'h7100, 1'b1);
        tick();
        set_desc(3, 32'd8, 32'h7001, 32'h7101, 1'b1);
        tick();
        ch_valid_i = '0;
        check_val("rstw_start", 64'(dma_start_o), 64'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_cnt = 0;
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
        check_val("rstw_no_done", 64'(ch_done_o), 64'd0);
        check_val("rstw_busy", 64'(busy_o), 64'd0);
        check_val("rstw_ready", 64'(ch_ready_o), 64'hF);
        check_val("rstw_cnt", 64'(done_cnt_o), 64'd0);
        repeat (3) begin
            tick();
            check_val("rstw_quiet_start", 64'(dma_start_o), 64'd0);
            check_val("rstw_quiet_done", 64'(ch_done_o), 64'd0);
        end

        // Counter wrap: 17 completions on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [3:0] exp_done;
            set_desc(i % 4, 32'd0, 32'(i), 32'(i), 1'b0);
            tick();
            ch_valid_i = '0;
            tick();
            exp_cnt++;
            exp_done = 4'd1 << (i % 4);
            check_val("wrap_done", 64'(ch_done_o), 64'(exp_done));
            check_val("wrap_cnt", 64'(done_cnt_o), 64'(exp_cnt & 15));
        end
        check_val("wrap_final", 64'(done_cnt_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
